// File: rtl/fpu_addsub_core.sv
// Multi-cycle IEEE-754 single-precision add/subtract core (denormals flushed to zero).
// Define FPU_ADDSUB_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module fpu_addsub_core #(
   parameter int NORM_MAX = 26
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        start,
   input  logic        sub,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  flags
);

   localparam int CW = $clog2(NORM_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t       state_q, state_d;
   logic [31:0]  a_q, a_d;
   logic [31:0]  b_q, b_d;          // b with the effective sign folded in
   logic         sign_q, sign_d;
   logic         diff_op_q, diff_op_d;
   logic [9:0]   exp_q, exp_d;
   logic [26:0]  xm_q, xm_d;
   logic [26:0]  ym_q, ym_d;
   logic [26:0]  man_q, man_d;
   logic [CW-1:0] norm_cnt_q, norm_cnt_d;
   logic [31:0]  result_q, result_d;
   logic [4:0]   flags_q, flags_d;

   // Operand classification
   logic a_exp_max, b_exp_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   assign a_exp_max = (a_q[30:23] == 8'hFF);
   assign b_exp_max = (b_q[30:23] == 8'hFF);
   assign a_nan     = a_exp_max & (|a_q[22:0]);
   assign b_nan     = b_exp_max & (|b_q[22:0]);
   assign a_inf     = a_exp_max & ~(|a_q[22:0]);
   assign b_inf     = b_exp_max & ~(|b_q[22:0]);
   assign a_zero    = (a_q[30:23] == 8'h00);
   assign b_zero    = (b_q[30:23] == 8'h00);

   // Alignment: order by magnitude, then a one-cycle right shift of the smaller operand
   logic        a_big;
   logic [31:0] x_w, y_w;
   logic [7:0]  align_d;
   logic [26:0] x27, y27, y_al;
   logic [53:0] y_wide;
   assign a_big   = (a_q[30:0] >= b_q[30:0]);
   assign x_w     = a_big ? a_q : b_q;
   assign y_w     = a_big ? b_q : a_q;
   assign align_d = x_w[30:23] - y_w[30:23];
   assign x27     = {1'b1, x_w[22:0], 3'b000};
   assign y27     = {1'b1, y_w[22:0], 3'b000};
   assign y_wide  = {y27, 27'd0} >> align_d;
   assign y_al    = (align_d >= 8'd27) ? 27'd1
                                       : {y_wide[53:28], y_wide[27] | (|y_wide[26:0])};

   logic [27:0] sum28;
   assign sum28 = diff_op_q ? ({1'b0, xm_q} - {1'b0, ym_q})
                            : ({1'b0, xm_q} + {1'b0, ym_q});

   // Rounding on the normalised {1,mant,G,R,S} value
   logic        inexact_w, inc_w, ovf_w;
   logic [24:0] rnd25;
   logic [9:0]  rnd_exp;
   logic [22:0] rnd_man;
   assign inexact_w = |man_q[2:0];
`ifdef FPU_ADDSUB_RNE_EN
   assign inc_w = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
`else
   assign inc_w = 1'b0;
`endif
   assign rnd25   = {1'b0, man_q[26:3]} + {24'd0, inc_w};
   assign rnd_exp = exp_q + {9'd0, rnd25[24]};
   assign rnd_man = rnd25[24] ? rnd25[23:1] : rnd25[22:0];
   assign ovf_w   = (rnd_exp >= 10'd255);

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sign_d     = sign_q;
      diff_op_d  = diff_op_q;
      exp_d      = exp_q;
      xm_d       = xm_q;
      ym_d       = ym_q;
      man_d      = man_q;
      norm_cnt_d = norm_cnt_q;
      result_d   = result_q;
      flags_d    = flags_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = operand_a;
               b_d     = {operand_b[31] ^ sub, operand_b[30:0]};
               state_d = S_UNPACK;
            end
         end
         S_UNPACK: begin
            state_d = S_DONE;
            if (a_nan || b_nan || (a_inf && b_inf && (a_q[31] != b_q[31]))) begin
               result_d = 32'h7FC00000;
               flags_d  = 5'b00001;
            end else if (a_inf) begin
               result_d = {a_q[31], 8'hFF, 23'd0};
               flags_d  = 5'b00000;
            end else if (b_inf) begin
               result_d = {b_q[31], 8'hFF, 23'd0};
               flags_d  = 5'b00000;
            end else if (a_zero && b_zero) begin
               result_d = {a_q[31] & b_q[31], 31'd0};
               flags_d  = 5'b10000;
            end else if (a_zero) begin
               result_d = b_q;
               flags_d  = 5'b00000;
            end else if (b_zero) begin
               result_d = a_q;
               flags_d  = 5'b00000;
            end else begin
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            sign_d    = x_w[31];
            diff_op_d = a_q[31] ^ b_q[31];
            exp_d     = {2'b00, x_w[30:23]};
            xm_d      = x27;
            ym_d      = y_al;
            state_d   = S_ADD;
         end
         S_ADD: begin
            // The first normalisation step (carry or already-normal) is folded into this cycle
            norm_cnt_d = '0;
            if (sum28 == 28'd0) begin
               result_d = 32'h00000000;
               flags_d  = 5'b10000;
               state_d  = S_DONE;
            end else if (sum28[27]) begin
               man_d   = {sum28[27:2], sum28[1] | sum28[0]};
               exp_d   = exp_q + 10'd1;
               state_d = S_ROUND;
            end else begin
               man_d   = sum28[26:0];
               state_d = sum28[26] ? S_ROUND : S_NORM;
            end
         end
         S_NORM: begin
            norm_cnt_d = norm_cnt_q + 1'b1;
            if (exp_q <= 10'd1) begin
               result_d = {sign_q, 31'd0};
               flags_d  = 5'b10100;
               state_d  = S_DONE;
            end else if (norm_cnt_q == CW'(NORM_MAX - 1)) begin
               result_d = {sign_q, 31'd0};
               flags_d  = 5'b10000;
               state_d  = S_DONE;
            end else begin
               man_d   = {man_q[25:0], 1'b0};
               exp_d   = exp_q - 10'd1;
               state_d = man_q[25] ? S_ROUND : S_NORM;
            end
         end
         S_ROUND: begin
            state_d = S_DONE;
            if (ovf_w) begin
`ifdef FPU_ADDSUB_RNE_EN
               result_d = {sign_q, 8'hFF, 23'd0};
`else
               result_d = {sign_q, 31'h7F7FFFFF};
`endif
               flags_d  = 5'b01010;
            end else begin
               result_d = {sign_q, rnd_exp[7:0], rnd_man};
               flags_d  = {1'b0, inexact_w, 3'b000};
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sign_q     <= 1'b0;
         diff_op_q  <= 1'b0;
         exp_q      <= '0;
         xm_q       <= '0;
         ym_q       <= '0;
         man_q      <= '0;
         norm_cnt_q <= '0;
         result_q   <= '0;
         flags_q    <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sign_q     <= sign_d;
         diff_op_q  <= diff_op_d;
         exp_q      <= exp_d;
         xm_q       <= xm_d;
         ym_q       <= ym_d;
         man_q      <= man_d;
         norm_cnt_q <= norm_cnt_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
      end
   end

   assign done   = (state_q == S_DONE);
   assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
   assign result = result_q;
   assign flags  = flags_q;

endmodule

// File: tb/tb_fpu_addsub_core.sv
// Directed-vector bench for fpu_addsub_core; expectations follow FPU_ADDSUB_RNE_EN when defined.
module tb_fpu_addsub_core;

   logic        clk = 1'b0;
   logic        arst;
   logic        start;
   logic        sub;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  flags;

   int total = 0;
   int bad   = 0;

   fpu_addsub_core #(.NORM_MAX(26)) dut (
      .clk(clk), .arst(arst), .start(start), .sub(sub),
      .operand_a(operand_a), .operand_b(operand_b),
      .busy(busy), .done(done), .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Launches one operation (start sampled at E0) and measures cycles until done.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_res, input logic [4:0] exp_flags,
                         input int exp_lat);
      int lat;
      @(posedge clk); #1;
      operand_a = a; operand_b = b; sub = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      $display("op %s a=%h b=%h sub=%0d -> result=%h flags=%b lat=%0d", tag, a, b, s, result, flags, lat);
      chk({tag, ".res"}, result, exp_res);
      chk({tag, ".flags"}, {27'd0, flags}, {27'd0, exp_flags});
      if (exp_lat >= 0) chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      int n_done;
      int first;
      arst = 1'b1; start = 1'b0; sub = 1'b0; operand_a = '0; operand_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.result", result, 32'h0);
      chk("rst.flags", {27'd0, flags}, 32'h0);
      chk("rst.done_busy", {30'd0, done, busy}, 32'h0);
      arst = 1'b0;

      run_op("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'b00000, 4);
      run_op("one_minus_075", 32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 5'b00000, 6);
      run_op("one_minus_two", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 5'b00000, 5);
      run_op("zero_sum",      32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 5'b10000, 3);
      run_op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 5'b00001, 1);
      run_op("nan_plus_one",  32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00001, 1);
      run_op("inf_plus_one",  32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 5'b00000, 1);
      run_op("zero_minus_two",32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 5'b00000, 1);
      run_op("negz_plus_negz",32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 5'b10000, 1);
      run_op("zero_minus_zero",32'h00000000,32'h00000000, 1'b1, 32'h00000000, 5'b10000, 1);
      run_op("denorm_plus_one",32'h00000001,32'h3F800000, 1'b0, 32'h3F800000, 5'b00000, 1);
      run_op("far_sticky",    32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 5'b01000, 4);
      run_op("underflow",     32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 5'b10100, -1);
`ifdef FPU_ADDSUB_RNE_EN
      run_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5'b01010, 4);
      run_op("tie_odd",       32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 5'b01000, 4);
`else
      run_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 5'b01010, 4);
      run_op("tie_odd",       32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 5'b01000, 4);
`endif
      run_op("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 5'b01000, 4);

      // Second start while busy must be ignored
      @(posedge clk); #1;
      operand_a = 32'h3F800000; operand_b = 32'h3F800000; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("dup.busy_e0", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      operand_a = 32'h7F800000; operand_b = 32'h7F800000; sub = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("dup.busy_e2", {31'd0, busy}, 32'd1);
      n_done = 0; first = -1;
      for (int n = 3; n <= 15; n++) begin
         @(posedge clk); #1;
         if (done) begin
            n_done++;
            if (first < 0) first = n;
         end
      end
      $display("op dup_start dones=%0d first=%0d result=%h", n_done, first, result);
      chk("dup.count", 32'(n_done), 32'd1);
      chk("dup.lat", 32'(first), 32'd4);
      chk("dup.result", result, 32'h40000000);

      // Reset while normalising aborts the operation
      @(posedge clk); #1;
      operand_a = 32'h3F800000; operand_b = 32'h3F400000; sub = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      arst = 1'b1;
      @(posedge clk); #1;
      arst = 1'b0;
      chk("abort.result", result, 32'h0);
      chk("abort.flags", {27'd0, flags}, 32'h0);
      chk("abort.done_busy", {30'd0, done, busy}, 32'h0);
      n_done = 0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      $display("op abort dones_after_reset=%0d", n_done);
      chk("abort.no_done", 32'(n_done), 32'd0);

      run_op("after_abort", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'b00000, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpu_addsub_core.md
Name: fpu_addsub_core

Overview:
Multi-cycle IEEE-754 single-precision add/subtract datapath. It sits directly downstream of the FPU register/command front end (fpu). The front end's start_add_st/start_sub_st states pulse start with the latched operand_a/operand_b. This core returns a packed result plus status flags for the front end's result/status registers and cmd_end.

Parameters:
NORM_MAX, 26, maximum left-normalise shift cycles before forcing a zero result. It is a safety bound and must be ≥ 26.

Ports:
clk  input  1  system clock
arst  input  1  reset, synchronous, active-high (sampled on posedge clk only)
start  input  1  one-cycle request; sampled only in IDLE
sub  input  1  1 = operand_a − operand_b, 0 = operand_a + operand_b; captured with start
operand_a  input  32  IEEE-754 single; captured with start
operand_b  input  32  IEEE-754 single; captured with start
busy  output  1  high in every state except IDLE and DONE
done  output  1  one-cycle pulse; result/flags valid in the same cycle
result  output  32  packed result; held until the next accepted start
flags  output  5  {zero, inexact, underflow, overflow, invalid}; held with result

Behaviour:
- Reset (arst=1 at posedge): state IDLE, result=0, flags=0, done=0, busy=0, internal registers cleared. Reset mid-operation aborts it and produces no done.
- start while not in IDLE: ignored. There is no queueing.
- Effective b sign = b[31] XOR sub.
- Denormal inputs (exp=0) are flushed to ±0. Denormal results are never produced.
- FSM: IDLE → UNPACK → {DONE | ALIGN} → ADD → NORM (k cycles) → ROUND → DONE → IDLE. All states except NORM last exactly one cycle.
- UNPACK, special cases (next state DONE):
  - Either operand is NaN (exp=255, mant≠0), or inf − inf with effective signs opposite: result=0x7FC00000, invalid=1.
  - Exactly one inf: that inf, with its effective sign.
  - Both zero: sign = a_s AND b_s_eff; zero=1.
  - One zero: the other operand with its effective sign.
  - Otherwise, next state ALIGN.
- ALIGN:
  - Order the operands by {exp,mant} magnitude into X (large) and Y.
  - d = ex − ey.
  - Form 27-bit {1,mant,G,R,S} mantissas. Shift Y right by d in one cycle; S is the OR of all bits shifted out. d ≥ 27 → Y = sticky only.
- ADD: 28-bit sum (signs equal) or X − Y (signs differ). Result sign = X sign.
- NORM:
  - Carry bit set: shift right 1, OR the dropped bit into S, exp+1, k=1.
  - Sum = 0: result +0, zero=1, go to DONE directly (skip ROUND).
  - Otherwise: while the hidden bit is 0, shift left 1 per cycle and decrement exp.
  - If exp would reach 0: underflow=1, result ±0, zero=1, go to DONE.
  - k = 1 + number of left shifts.
- ROUND:
  - inexact = G|R|S.
  - Rounding rule is selected by the optional feature (see below).
  - A rounding carry out of the mantissa renormalises and increments exp.
  - exp ≥ 255 → result ±inf (0x7F800000 | sign), overflow=1, inexact=1.
- DONE: result/flags registered and done=1 for one cycle. The next state is always IDLE.
- Latency, with start sampled at edge E0:
  - Special-case result: done high after E1.
  - Normal path: done high after E(3+k).
  - Zero sum: done high after E3.

Optional Feature:
FPU_ADDSUB_RNE_EN
- Defined: round-to-nearest-even. Increment when G & (R|S|lsb).
- Undefined: truncate (round toward zero) and never increment.
- inexact is reported identically in both builds.
- Overflow in the truncate build saturates to ±0x7F7FFFFF instead of inf; overflow=1 still.

Test Plan:
- 1.0 + 1.0: a=0x3F800000, b=0x3F800000, sub=0, start at E0 → done after E4, result 0x40000000, flags 0.
- 1.0 − 0.75: a=0x3F800000, b=0x3F400000, sub=1 → result 0x3E800000, k=3, done after E6, flags 0.
- 1.5 − 1.5: a=b=0x3FC00000, sub=1 → result 0x00000000, zero=1, done after E3.
- inf − inf: a=b=0x7F800000, sub=1 → result 0x7FC00000, invalid=1, done after E1. Then 0x7F7FFFFF + 0x7F7FFFFF → RNE build 0x7F800000, truncate build 0x7F7FFFFF, overflow=1.
- Rounding tie, a=0x3F800001, b=0x33800000:
  - RNE build: result 0x3F800002.
  - Truncate build: result 0x3F800001.
  - Both builds: inexact=1.
  - With a=0x3F800000: RNE gives 0x3F800000 (tie to even).
- Control:
  - A second start pulse mid-operation is ignored: busy stays high and exactly one done is produced.
  - arst asserted during NORM → no done, result=0 and flags=0 the next cycle.
  - A new start afterwards completes normally.
